// File: rtl/spi_fl_pkg.sv
// Shared constants and command decode for the flash-side SPI responder.
package spi_fl_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CMD_W-1:0] CMD_WREN = 8'h06;
    localparam logic [CMD_W-1:0] CMD_RDSR = 8'h05;
    localparam logic [CMD_W-1:0] CMD_RDID = 8'h9F;
    localparam logic [CMD_W-1:0] CMD_READ = 8'h03;
    localparam logic [CMD_W-1:0] CMD_WRSR = 8'h01;
    localparam logic [CMD_W-1:0] CMD_PP   = 8'h02;
    localparam logic [CMD_W-1:0] CMD_SE   = 8'h20;

    // Frame types, same encoding as the master's commtype
    localparam logic [TYPE_W-1:0] FT_CMD     = 3'd0;
    localparam logic [TYPE_W-1:0] FT_RD      = 3'd1;
    localparam logic [TYPE_W-1:0] FT_ADDR_RD = 3'd2;
    localparam logic [TYPE_W-1:0] FT_WR      = 3'd3;
    localparam logic [TYPE_W-1:0] FT_ADDR_WR = 3'd4;
    localparam logic [TYPE_W-1:0] FT_ADDR    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RD, ST_DONE, ST_ERR
    } state_e;

    typedef struct packed {
        logic              known;
        logic [TYPE_W-1:0] ftype;
    } cmd_dec_t;

    // Map a command byte to its frame type; unknown codes clear 'known'
    function automatic cmd_dec_t decode_cmd(input logic [CMD_W-1:0] code);
        cmd_dec_t d;
        d.known = 1'b1;
        d.ftype = FT_CMD;
        case (code)
            CMD_WREN:           d.ftype = FT_CMD;
            CMD_RDSR, CMD_RDID: d.ftype = FT_RD;
            CMD_READ:           d.ftype = FT_ADDR_RD;
            CMD_WRSR:           d.ftype = FT_WR;
            CMD_PP:             d.ftype = FT_ADDR_WR;
            CMD_SE:             d.ftype = FT_ADDR;
            default:            d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses taken from the last two stages.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= {SYNC_STAGES{RST_VAL}};
        else        sr <= {sr[SYNC_STAGES-2:0], din};
    end

    // Edge pulses: newer stage differs from the oldest stage
    always_comb begin
        rise_c = sr[SYNC_STAGES-2] & ~sr[SYNC_STAGES-1];
        fall_c = ~sr[SYNC_STAGES-2] & sr[SYNC_STAGES-1];
    end

endmodule

// File: rtl/spi_slave_fl.sv
// SPI mode-0 flash-side responder: decodes cmd/addr/data frames for a back-end.
module spi_slave_fl
    import spi_fl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_MISO   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic                ss,
    input  logic                mosi,
    output logic                miso,
    output logic                req_valid,
    output logic [TYPE_W-1:0]   req_type,
    output logic [CMD_W-1:0]    req_cmd,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W-1:0]   req_data,
    output logic                rd_req,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                frame_err
);

    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic mosi_s;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(sclk), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .din(ss), .rise_c(ss_rise), .fall_c(ss_fall)
    );

    // Plain synchronizer for mosi; data is long stable around sclk rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sr <= '0;
        else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sr[SYNC_STAGES-1];

    state_e              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
    logic [DATA_W-1:0]   rx, rx_nxt, rx_bit, tx, tx_nxt, fin_data;
    logic [TYPE_W-1:0]   ftype, ftype_nxt;
    logic [CMD_W-1:0]    cmd_q, cmd_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                ld_pend, complete;
    cmd_dec_t            dec;
    logic                miso_nxt, req_valid_nxt, rd_req_nxt, frame_err_nxt;
    logic [TYPE_W-1:0]   req_type_nxt;
    logic [CMD_W-1:0]    req_cmd_nxt;
    logic [ADDR_W-1:0]   req_addr_nxt;
    logic [DATA_W-1:0]   req_data_nxt;

    // State, shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            ftype     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            ld_pend   <= 1'b0;
            miso      <= IDLE_MISO;
            req_valid <= 1'b0;
            req_type  <= '0;
            req_cmd   <= '0;
            req_addr  <= '0;
            req_data  <= '0;
            rd_req    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx        <= rx_nxt;
            tx        <= tx_nxt;
            ftype     <= ftype_nxt;
            cmd_q     <= cmd_nxt;
            addr_q    <= addr_nxt;
            ld_pend   <= rd_req;
            miso      <= miso_nxt;
            req_valid <= req_valid_nxt;
            req_type  <= req_type_nxt;
            req_cmd   <= req_cmd_nxt;
            req_addr  <= req_addr_nxt;
            req_data  <= req_data_nxt;
            rd_req    <= rd_req_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Frame sequencing: shift phases, read fetch, completion and abort
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rx_nxt        = rx;
        tx_nxt        = tx;
        ftype_nxt     = ftype;
        cmd_nxt       = cmd_q;
        addr_nxt      = addr_q;
        miso_nxt      = miso;
        req_valid_nxt = 1'b0;
        req_type_nxt  = req_type;
        req_cmd_nxt   = req_cmd;
        req_addr_nxt  = req_addr;
        req_data_nxt  = req_data;
        rd_req_nxt    = 1'b0;
        frame_err_nxt = 1'b0;
        complete      = 1'b0;
        fin_data      = '0;
        rx_bit        = {rx[DATA_W-2:0], mosi_s};
        cnt_inc       = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
        dec           = decode_cmd(rx_bit[CMD_W-1:0]);

        // Back-end data arrives one clk after rd_req
        if (ld_pend) tx_nxt = rd_data;

        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_nxt = ST_CMD;
                    cnt_nxt   = '0;
                    rx_nxt    = '0;
                    ftype_nxt = '0;
                    cmd_nxt   = '0;
                    addr_nxt  = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    rx_nxt  = rx_bit;
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_CMD) begin
                        cnt_nxt   = '0;
                        cmd_nxt   = rx_bit[CMD_W-1:0];
                        ftype_nxt = dec.ftype;
                        if (!dec.known) begin
                            state_nxt     = ST_ERR;
                            frame_err_nxt = 1'b1;
                        end else begin
                            case (dec.ftype)
                                FT_CMD:  complete = 1'b1;
                                FT_RD: begin
                                    state_nxt  = ST_RD;
                                    rd_req_nxt = 1'b1;
                                end
                                FT_WR:   state_nxt = ST_WDATA;
                                default: state_nxt = ST_ADDR;
                            endcase
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    rx_nxt  = rx_bit;
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_ADDR) begin
                        cnt_nxt  = '0;
                        addr_nxt = rx_bit[ADDR_W-1:0];
                        case (ftype)
                            FT_ADDR_RD: begin
                                state_nxt  = ST_RD;
                                rd_req_nxt = 1'b1;
                            end
                            FT_ADDR_WR: state_nxt = ST_WDATA;
                            default:    complete  = 1'b1;
                        endcase
                    end
                end
            end
            ST_WDATA: begin
                if (sclk_rise) begin
                    rx_nxt  = rx_bit;
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_DATA) begin
                        complete = 1'b1;
                        fin_data = rx_bit;
                    end
                end
            end
            ST_RD: begin
                // Master samples bit 0 on the rise after it was driven
                if (sclk_rise && cnt == CNT_FULL) begin
                    complete = 1'b1;
                end else if (sclk_fall && cnt != CNT_FULL) begin
                    miso_nxt = tx[DATA_W-1];
                    tx_nxt   = {tx[DATA_W-2:0], 1'b0};
                    cnt_nxt  = cnt_inc;
                end
            end
            ST_DONE, ST_ERR: ;
            default: state_nxt = ST_IDLE;
        endcase

        if (complete) begin
            state_nxt     = ST_DONE;
            req_valid_nxt = 1'b1;
            req_type_nxt  = ftype_nxt;
            req_cmd_nxt   = cmd_nxt;
            req_addr_nxt  = addr_nxt;
            req_data_nxt  = fin_data;
        end

        // ss high ends the frame; before completion it is an abort
        if (ss_rise && state_nxt != ST_IDLE) begin
            if (state_nxt inside {ST_CMD, ST_ADDR, ST_WDATA, ST_RD}) begin
                frame_err_nxt = 1'b1;
                rd_req_nxt    = 1'b0;
            end
            state_nxt = ST_IDLE;
        end

        if (state_nxt != ST_RD) miso_nxt = IDLE_MISO;
    end

endmodule

// File: tb/tb_spi_slave_fl.sv
// Self-checking bench for spi_slave_fl: SPI master model, back-end model, frame model.
module tb_spi_slave_fl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, req_valid, rd_req, frame_err;
    logic [2:0]  req_type;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] rd_data = 32'h0;

    spi_slave_fl #(.SYNC_STAGES(2), .IDLE_MISO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .req_valid(req_valid), .req_type(req_type), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_data(req_data), .rd_req(rd_req),
        .rd_data(rd_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hp = 6;
    logic [31:0] be_val = 32'h0;

    // Back-end: fixed one-cycle read latency, zero otherwise
    always @(posedge clk) rd_data <= rd_req ? be_val : 32'h0;

    // Event monitor: running totals plus fields of the latest request
    int n_rv = 0, n_rd = 0, n_fe = 0, n_low = 0;
    logic [2:0]  c_type = 3'h0;
    logic [7:0]  c_cmd = 8'h0;
    logic [23:0] c_addr = 24'h0;
    logic [31:0] c_data = 32'h0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid) begin
                n_rv++;
                c_type = req_type; c_cmd = req_cmd; c_addr = req_addr; c_data = req_data;
            end
            if (rd_req) n_rd++;
            if (frame_err) n_fe++;
            if (miso !== 1'b1) n_low++;
        end
    end

    int s_rv, s_rd, s_fe, s_low;

    // Reference: frame type from the command table, -1 for unknown codes
    function automatic int model_type(input logic [7:0] c);
        case (c)
            8'h06:        return 0;
            8'h05, 8'h9F: return 1;
            8'h03:        return 2;
            8'h01:        return 3;
            8'h02:        return 4;
            8'h20:        return 5;
            default:      return -1;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_frame();
        s_rv = n_rv; s_rd = n_rd; s_fe = n_fe; s_low = n_low;
        hp = $urandom_range(5, 8);
        ss = 1'b0;
        tick(hp);
    endtask

    task automatic end_frame();
        tick(hp);
        ss = 1'b1;
        tick(8);
    endtask

    // Mode-0 master: set mosi while sclk low, capture miso at the rising edge
    task automatic shift_bits(input logic [31:0] val, input int n, output logic [31:0] cap);
        cap = 32'h0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            tick(hp);
            sclk = 1'b1;
            cap = {cap[30:0], miso};
            tick(hp);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [23:0] addr,
                              input logic [31:0] wd, output logic [31:0] cap);
        int t;
        logic [31:0] dummy;
        t = model_type(cmd);
        cap = 32'h0;
        begin_frame();
        shift_bits({24'h0, cmd}, 8, dummy);
        if (t < 0) shift_bits($urandom, 24, dummy);
        if (t == 2 || t == 4 || t == 5) shift_bits({8'h0, addr}, 24, dummy);
        if (t == 3 || t == 4) shift_bits(wd, 32, dummy);
        if (t == 1 || t == 2) shift_bits(32'h0, 32, cap);
        end_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", miso); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if ({req_type, req_cmd, req_addr, req_data} !== 67'h0) begin errors++;
            $display("FAIL reset_req_fields: got %h %h %h %h expected all 0", req_type, req_cmd, req_addr, req_data); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_wren();
        logic [31:0] cap;
        send_frame(8'h06, 24'($urandom), $urandom, cap);
        checks++; if ((n_rv - s_rv) !== 1) begin errors++; $display("FAIL wren_valid_count: got %0d expected 1", n_rv - s_rv); end
        checks++; if ({c_type, c_cmd, c_addr, c_data} !== {3'd0, 8'h06, 24'h0, 32'h0}) begin errors++;
            $display("FAIL wren_fields: got %h %h %h %h expected 0 06 000000 00000000", c_type, c_cmd, c_addr, c_data); end
        checks++; if ((n_rd - s_rd) !== 0) begin errors++; $display("FAIL wren_rd_req: got %0d expected 0", n_rd - s_rd); end
        checks++; if ((n_low - s_low) !== 0) begin errors++; $display("FAIL wren_miso_idle: got %0d low clks expected 0", n_low - s_low); end
    endtask

    task automatic test_read();
        logic [31:0] cap;
        be_val = 32'hDEADBEEF;
        send_frame(8'h03, 24'h123456, 32'h0, cap);
        checks++; if ((n_rd - s_rd) !== 1) begin errors++; $display("FAIL read_rd_req: got %0d expected 1", n_rd - s_rd); end
        checks++; if (cap !== 32'hDEADBEEF) begin errors++; $display("FAIL read_miso_data: got %h expected deadbeef", cap); end
        checks++; if ((n_rv - s_rv) !== 1) begin errors++; $display("FAIL read_valid_count: got %0d expected 1", n_rv - s_rv); end
        checks++; if ({c_type, c_cmd, c_addr, c_data} !== {3'd2, 8'h03, 24'h123456, 32'h0}) begin errors++;
            $display("FAIL read_fields: got %h %h %h %h expected 2 03 123456 00000000", c_type, c_cmd, c_addr, c_data); end
    endtask

    task automatic test_pp();
        logic [31:0] cap;
        send_frame(8'h02, 24'h000100, 32'hCAFEF00D, cap);
        checks++; if ((n_rv - s_rv) !== 1) begin errors++; $display("FAIL pp_valid_count: got %0d expected 1", n_rv - s_rv); end
        checks++; if ({c_type, c_cmd, c_addr, c_data} !== {3'd4, 8'h02, 24'h000100, 32'hCAFEF00D}) begin errors++;
            $display("FAIL pp_fields: got %h %h %h %h expected 4 02 000100 cafef00d", c_type, c_cmd, c_addr, c_data); end
        checks++; if ((n_low - s_low) !== 0) begin errors++; $display("FAIL pp_miso_idle: got %0d low clks expected 0", n_low - s_low); end
    endtask

    task automatic test_unknown();
        logic [31:0] cap;
        send_frame(8'hAB, 24'h0, 32'h0, cap);
        checks++; if ((n_fe - s_fe) !== 1) begin errors++; $display("FAIL unk_frame_err: got %0d expected 1", n_fe - s_fe); end
        checks++; if ((n_rv - s_rv) !== 0 || (n_rd - s_rd) !== 0) begin errors++;
            $display("FAIL unk_no_req: got valid=%0d rd=%0d expected 0 0", n_rv - s_rv, n_rd - s_rd); end
        checks++; if ((n_low - s_low) !== 0) begin errors++; $display("FAIL unk_miso_idle: got %0d low clks expected 0", n_low - s_low); end
        send_frame(8'h06, 24'h0, 32'h0, cap);
        checks++; if ((n_rv - s_rv) !== 1 || c_cmd !== 8'h06 || (n_fe - s_fe) !== 0) begin errors++;
            $display("FAIL unk_next_wren: got valid=%0d cmd=%h err=%0d expected 1 06 0", n_rv - s_rv, c_cmd, n_fe - s_fe); end
    endtask

    task automatic test_abort();
        logic [31:0] cap;
        begin_frame();
        shift_bits(32'h20, 8, cap);
        shift_bits(32'h5, 4, cap);
        end_frame();
        checks++; if ((n_fe - s_fe) !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", n_fe - s_fe); end
        checks++; if ((n_rv - s_rv) !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", n_rv - s_rv); end
        be_val = 32'h00EF4018;
        send_frame(8'h9F, 24'h0, 32'h0, cap);
        checks++; if (cap !== 32'h00EF4018) begin errors++; $display("FAIL rdid_miso_data: got %h expected 00ef4018", cap); end
        checks++; if ((n_rv - s_rv) !== 1 || c_type !== 3'd1 || (n_rd - s_rd) !== 1) begin errors++;
            $display("FAIL rdid_req: got valid=%0d type=%0d rd=%0d expected 1 1 1", n_rv - s_rv, c_type, n_rd - s_rd); end
    endtask

    task automatic test_extra_sclk();
        logic [31:0] cap;
        begin_frame();
        shift_bits(32'h06, 8, cap);
        shift_bits($urandom, 5, cap);
        end_frame();
        checks++; if ((n_rv - s_rv) !== 1 || c_type !== 3'd0 || (n_fe - s_fe) !== 0) begin errors++;
            $display("FAIL extra_sclk_req: got valid=%0d type=%0d err=%0d expected 1 0 0", n_rv - s_rv, c_type, n_fe - s_fe); end
        checks++; if ((n_low - s_low) !== 0) begin errors++; $display("FAIL extra_sclk_miso: got %0d low clks expected 0", n_low - s_low); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] cap;
        logic [23:0] a;
        be_val = 32'h0000FFFF;
        begin_frame();
        shift_bits(32'h03, 8, cap);
        shift_bits(32'h00ABCD, 24, cap);
        shift_bits(32'h0, 10, cap);
        mosi = 1'b0;
        tick(hp);
        sclk = 1'b1;
        tick(2);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_read_bit21: got %b expected 0", miso); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (miso !== 1'b1) begin errors++; $display("FAIL mid_reset_miso: got %b expected 1", miso); end
        checks++; if ({req_valid, rd_req, frame_err, req_type, req_cmd, req_addr, req_data} !== 70'h0) begin errors++;
            $display("FAIL mid_reset_outputs: got %b%b%b %h %h %h %h expected all 0",
                     req_valid, rd_req, frame_err, req_type, req_cmd, req_addr, req_data); end
        sclk = 1'b0;
        ss = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        be_val = $urandom;
        a = 24'($urandom);
        send_frame(8'h03, a, 32'h0, cap);
        checks++; if (cap !== be_val) begin errors++; $display("FAIL post_reset_read_data: got %h expected %h", cap, be_val); end
        checks++; if ((n_rv - s_rv) !== 1 || c_addr !== a || c_type !== 3'd2) begin errors++;
            $display("FAIL post_reset_read_req: got valid=%0d addr=%h type=%0d expected 1 %h 2", n_rv - s_rv, c_addr, c_type, a); end
    endtask

    task automatic test_random();
        logic [7:0]  codes [7] = '{8'h06, 8'h05, 8'h9F, 8'h03, 8'h01, 8'h02, 8'h20};
        logic [7:0]  cmd;
        logic [23:0] a;
        logic [31:0] wd, cap, exp_addr, exp_data;
        int t;
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cmd = 8'($urandom);
                while (model_type(cmd) >= 0) cmd = 8'($urandom);
            end else begin
                cmd = codes[$urandom_range(0, 6)];
            end
            a = 24'($urandom);
            wd = $urandom;
            be_val = $urandom;
            t = model_type(cmd);
            send_frame(cmd, a, wd, cap);
            if (t < 0) begin
                checks++; if ((n_fe - s_fe) !== 1 || (n_rv - s_rv) !== 0 || (n_rd - s_rd) !== 0) begin errors++;
                    $display("FAIL rnd_unknown cmd=%h: got err=%0d valid=%0d rd=%0d expected 1 0 0",
                             cmd, n_fe - s_fe, n_rv - s_rv, n_rd - s_rd); end
            end else begin
                exp_addr = (t == 2 || t == 4 || t == 5) ? {8'h0, a} : 32'h0;
                exp_data = (t == 3 || t == 4) ? wd : 32'h0;
                checks++; if ((n_rv - s_rv) !== 1 || (n_fe - s_fe) !== 0) begin errors++;
                    $display("FAIL rnd_valid cmd=%h: got valid=%0d err=%0d expected 1 0", cmd, n_rv - s_rv, n_fe - s_fe); end
                checks++; if ({c_type, c_cmd, c_addr, c_data} !== {3'(t), cmd, exp_addr[23:0], exp_data}) begin errors++;
                    $display("FAIL rnd_fields cmd=%h: got %h %h %h %h expected %h %h %h %h",
                             cmd, c_type, c_cmd, c_addr, c_data, 3'(t), cmd, exp_addr[23:0], exp_data); end
                if (t == 1 || t == 2) begin
                    checks++; if (cap !== be_val || (n_rd - s_rd) !== 1) begin errors++;
                        $display("FAIL rnd_read cmd=%h: got data=%h rd=%0d expected %h 1", cmd, cap, n_rd - s_rd, be_val); end
                end else begin
                    checks++; if ((n_low - s_low) !== 0 || (n_rd - s_rd) !== 0) begin errors++;
                        $display("FAIL rnd_no_read cmd=%h: got low=%0d rd=%0d expected 0 0", cmd, n_low - s_low, n_rd - s_rd); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wren();
        test_read();
        test_pp();
        test_unknown();
        test_abort();
        test_extra_sclk();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_fl.md
Name: spi_slave_fl

Overview:
- SPI mode-0 responder (flash-device side) for the flash SPI master's frames: command byte, optional 24-bit address, then 32-bit write data in or 32-bit read data out.
- Oversamples sclk/ss/mosi in the system clock domain and decodes the command into a frame type.
- Presents completed requests to a back-end (memory model or register file) and fetches read data from it.
- Used as the bench/FPGA counterpart of the master and as a flash model.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sclk/ss/mosi (minimum 2).
- IDLE_MISO, 1'b1, miso level when not shifting read data.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst_n  input  1  asynchronous reset, active-low.
- sclk  input  1  SPI clock from master, idle low.
- ss  input  1  slave select, active-low.
- mosi  input  1  master data; sampled on sclk rising edge, MSB first.
- miso  output  1  slave data; changed on sclk falling edge, MSB first.
- req_valid  output  1  one-clk pulse: frame complete.
- req_type  output  3  frame type 0..5, same encoding as the master's commtype.
- req_cmd  output  8  command byte.
- req_addr  output  24  address; 0 for types without address.
- req_data  output  32  write data; 0 for types without data.
- rd_req  output  1  one-clk pulse requesting read data.
- rd_data  input  32  back-end read data; valid on the clk after rd_req (fixed 1-cycle latency).
- frame_err  output  1  one-clk pulse on a malformed or aborted frame.

Behaviour:
- Reset: miso=IDLE_MISO; req_valid, rd_req, frame_err=0; req_* = 0; state IDLE; shift counters cleared. Takes effect asynchronously, including mid-frame.
- Input sampling:
  - sclk, ss and mosi pass through SYNC_STAGES flops.
  - Edges are detected from the last two sync stages.
  - mosi is sampled on the same clk the rising edge is detected.
- Command decode, applied after 8 bits:
  - 0x06 -> type 0 (cmd only).
  - 0x05, 0x9F -> type 1 (cmd + 32-bit answer).
  - 0x03 -> type 2 (cmd + addr + answer).
  - 0x01 -> type 3 (cmd + 32-bit data).
  - 0x02 -> type 4 (cmd + addr + data).
  - 0x20 -> type 5 (cmd + addr).
  - Any other code -> ERR.
- State machine:
  - IDLE -> CMD on ss falling.
  - CMD: shift 8 bits, then:
    - type 0 -> DONE.
    - types 2/4/5 -> ADDR.
    - type 3 -> WDATA.
    - type 1 -> RD.
    - unknown -> ERR.
  - ADDR: shift 24 bits, then:
    - type 2 -> RD.
    - type 4 -> WDATA.
    - type 5 -> DONE.
  - WDATA: shift 32 bits -> DONE.
  - RD:
    - rd_req pulses on the clk the last cmd/addr bit is sampled.
    - rd_data is loaded into the TX shift register one clk later.
    - Bit 31 is driven on the next sclk falling edge; bits 30..0 follow on successive falling edges.
    - After bit 0 -> DONE.
  - DONE: req_valid pulses once, on the clk the last bit is sampled (write types) or after bit 0 is driven (type 1/2). Then wait for ss high -> IDLE.
  - ERR: frame_err pulses once; ignore mosi; miso=IDLE_MISO until ss high -> IDLE.
- ss rises before DONE (mid CMD/ADDR/WDATA/RD):
  - Abort, frame_err pulses, no req_valid, miso=IDLE_MISO, return to IDLE.
- Extra sclk pulses in DONE: ignored; miso=IDLE_MISO.
- ss rising and the final sampling edge detected on the same clk: the bit counts; frame completes normally.
- miso equals IDLE_MISO whenever not in RD.
- Counters saturate at their terminal count; no wrap within a frame.

Decomposition:
- Package spi_fl_pkg:
  - command code constants (CMD_WREN, CMD_RDSR, CMD_RDID, CMD_READ, CMD_WRSR, CMD_PP, CMD_SE).
  - frame type constants 0..5 shared with the master.
  - field widths 8/24/32.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiated for sclk and ss; mosi uses a plain sync.

Test Plan:
- WREN: ss low, mosi 0x06, ss high -> one req_valid, type 0, cmd 0x06, addr 0, data 0; no rd_req; miso stays 1.
- READ: cmd 0x03, addr 0x123456, back-end returns 0xDEADBEEF -> rd_req once after bit 32; master-side capture of miso = 0xDEADBEEF; req_valid type 2, addr 0x123456.
- PP: cmd 0x02, addr 0x000100, data 0xCAFEF00D -> req_valid type 4, addr 0x000100, data 0xCAFEF00D; miso constant 1.
- Unknown cmd 0xAB followed by 24 clocks -> frame_err once after bit 8; no req_valid, no rd_req; next WREN frame accepted normally.
- Abort: ss raised after 12 bits of a 0x20 frame -> frame_err once, no req_valid; next RDID (0x9F) with rd_data 0x00EF4018 returns 0x00EF4018.
- Reset mid-READ (rst_n low during bit 10 of data) -> miso=1 immediately, outputs zero; after release, a clean READ frame completes correctly.
